// File: rtl/fifo_ref_model.sv
// -----------------------------------------------------------------------------
// fifo_ref_model
//   Cycle-accurate synchronous FIFO reference model. It sits beside the FIFO
//   under test, sees the same data_in/wr_en/rd_en, and drives the g_* golden
//   outputs. It is plain synthesizable RTL, so it can also stand in as a FIFO.
//
// Configuration macro:
//   FIFO_REF_FWFT_EN - when defined, first-word fall-through: the head word is
//                      shown on g_data_out combinationally whenever the FIFO
//                      is not empty. When undefined, reads have one clock of
//                      registered latency.
//
// Parameters:
//   FIFO_WIDTH - data width in bits
//   FIFO_DEPTH - number of entries (>= 4, need not be a power of two)
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   data_in       in   write data
//   wr_en         in   write request
//   rd_en         in   read request
//   g_data_out    out  read data
//   g_wr_ack      out  previous-cycle write accepted
//   g_overflow    out  previous-cycle write rejected (full)
//   g_underflow   out  previous-cycle read rejected (empty)
//   g_full        out  count == FIFO_DEPTH
//   g_empty       out  count == 0
//   g_almostfull  out  count == FIFO_DEPTH-1
//   g_almostempty out  count == 1
//   g_count       out  current occupancy
// -----------------------------------------------------------------------------

// Occupancy checker: the count may never leave the range 0..FIFO_DEPTH.
// An underflowing count wraps to a large unsigned value, so one upper-bound
// check covers both directions.
module fifo_ref_model_chk #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input logic             clk,
  input logic             rst_n,
  input logic [CNT_W-1:0] count
);

  count_in_range_a : assert property (
    @(posedge clk) disable iff (!rst_n) (count <= CNT_W'(FIFO_DEPTH))
  );

endmodule

module fifo_ref_model #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [FIFO_WIDTH-1:0]       data_in,
  input  logic                        wr_en,
  input  logic                        rd_en,
  output logic [FIFO_WIDTH-1:0]       g_data_out,
  output logic                        g_wr_ack,
  output logic                        g_overflow,
  output logic                        g_underflow,
  output logic                        g_full,
  output logic                        g_empty,
  output logic                        g_almostfull,
  output logic                        g_almostempty,
  output logic [$clog2(FIFO_DEPTH):0] g_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FIFO_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [CNT_W-1:0]      count_nxt_s;
  logic [FIFO_WIDTH-1:0] data_out_r;
  logic                  wr_ack_r;
  logic                  overflow_r;
  logic                  underflow_r;

  logic                  full_s;
  logic                  empty_s;
  logic                  wr_accept_s;
  logic                  rd_accept_s;

  // Pointers wrap explicitly so a non-power-of-two depth works.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(FIFO_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign full_s  = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty_s = (count_r == {CNT_W{1'b0}});

  // Full blocks only the write and empty blocks only the read, so a
  // simultaneous request at either boundary degrades to a single operation.
  assign wr_accept_s = wr_en && !full_s;
  assign rd_accept_s = rd_en && !empty_s;

  // Next occupancy: a simultaneous accepted write and read leave it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_accept_s, rd_accept_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array; deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (wr_accept_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (rd_accept_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_nxt_s;
    end
  end

  // Read data register plus the one-cycle handshake pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_r  <= {FIFO_WIDTH{1'b0}};
      wr_ack_r    <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (rd_accept_s) begin
        data_out_r <= mem_r[rd_ptr_r];
      end
      wr_ack_r    <= wr_accept_s;
      overflow_r  <= wr_en && full_s;
      underflow_r <= rd_en && empty_s;
    end
  end

`ifdef FIFO_REF_FWFT_EN
  // Head word falls through; when empty, the last popped word is held.
  assign g_data_out = empty_s ? data_out_r : mem_r[rd_ptr_r];
`else
  assign g_data_out = data_out_r;
`endif

  assign g_wr_ack      = wr_ack_r;
  assign g_overflow    = overflow_r;
  assign g_underflow   = underflow_r;
  assign g_full        = full_s;
  assign g_empty       = empty_s;
  assign g_almostfull  = (count_r == CNT_W'(FIFO_DEPTH - 1));
  assign g_almostempty = (count_r == CNT_W'(1));
  assign g_count       = count_r;

  fifo_ref_model_chk #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W     (CNT_W)
  ) u_chk (
    .clk  (clk),
    .rst_n(rst_n),
    .count(count_r)
  );

endmodule

// File: tb/tb_fifo_ref_model.sv
// -----------------------------------------------------------------------------
// tb_fifo_ref_model
//   Directed self-checking bench for fifo_ref_model (default build, 1-cycle
//   registered read latency). FIFO_WIDTH=16, FIFO_DEPTH=8.
// -----------------------------------------------------------------------------
module tb_fifo_ref_model;

  localparam int W = 16;
  localparam int D = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] data_in;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] g_data_out;
  logic         g_wr_ack;
  logic         g_overflow;
  logic         g_underflow;
  logic         g_full;
  logic         g_empty;
  logic         g_almostfull;
  logic         g_almostempty;
  logic [3:0]   g_count;

  int total;
  int bad;

  fifo_ref_model #(
    .FIFO_WIDTH(W),
    .FIFO_DEPTH(D)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .g_data_out   (g_data_out),
    .g_wr_ack     (g_wr_ack),
    .g_overflow   (g_overflow),
    .g_underflow  (g_underflow),
    .g_full       (g_full),
    .g_empty      (g_empty),
    .g_almostfull (g_almostfull),
    .g_almostempty(g_almostempty),
    .g_count      (g_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic step(input logic wr, input logic rd, input logic [W-1:0] din);
    wr_en   = wr;
    rd_en   = rd;
    data_in = din;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
  endtask

  task automatic chk_pulses(input string tag, input logic ack, input logic ovf, input logic udf);
    chk({tag, "_wr_ack"}, 32'(g_wr_ack), 32'(ack));
    chk({tag, "_overflow"}, 32'(g_overflow), 32'(ovf));
    chk({tag, "_underflow"}, 32'(g_underflow), 32'(udf));
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = 16'h0000;

    // Reset and idle
    #12 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000);
    chk("rst_empty", 32'(g_empty), 32'd1);
    chk("rst_full", 32'(g_full), 32'd0);
    chk("rst_count", 32'(g_count), 32'd0);
    chk("rst_data", 32'(g_data_out), 32'd0);
    chk("rst_afull", 32'(g_almostfull), 32'd0);
    chk("rst_aempty", 32'(g_almostempty), 32'd0);
    chk_pulses("rst", 1'b0, 1'b0, 1'b0);

    // Fill 0x0001..0x0008
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, W'(i));
      chk("fill_ack", 32'(g_wr_ack), 32'd1);
      chk("fill_count", 32'(g_count), 32'(i));
      chk("fill_afull", 32'(g_almostfull), (i == 7) ? 32'd1 : 32'd0);
      chk("fill_full", 32'(g_full), (i == 8) ? 32'd1 : 32'd0);
      chk("fill_aempty", 32'(g_almostempty), (i == 1) ? 32'd1 : 32'd0);
    end

    // Ninth write is rejected
    step(1'b1, 1'b0, 16'h0009);
    chk_pulses("ovf", 1'b0, 1'b1, 1'b0);
    chk("ovf_count", 32'(g_count), 32'd8);

    // Drain in order
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 16'h0000);
      chk("drain_data", 32'(g_data_out), 32'(i));
      chk("drain_count", 32'(g_count), 32'(8 - i));
      chk("drain_aempty", 32'(g_almostempty), (i == 7) ? 32'd1 : 32'd0);
      chk("drain_empty", 32'(g_empty), (i == 8) ? 32'd1 : 32'd0);
      chk("drain_udf", 32'(g_underflow), 32'd0);
    end

    // Ninth read is rejected, data holds
    step(1'b0, 1'b1, 16'h0000);
    chk_pulses("udf", 1'b0, 1'b0, 1'b1);
    chk("udf_data", 32'(g_data_out), 32'h0008);

    // Simultaneous at empty: write only
    step(1'b1, 1'b1, 16'h00A1);
    chk_pulses("sim0", 1'b1, 1'b0, 1'b1);
    chk("sim0_count", 32'(g_count), 32'd1);
    chk("sim0_data", 32'(g_data_out), 32'h0008);

    for (int i = 2; i <= 8; i++) step(1'b1, 1'b0, W'(16'h00A0 + i));
    chk("refill_full", 32'(g_full), 32'd1);

    // Simultaneous at full: read only
    step(1'b1, 1'b1, 16'h00B0);
    chk_pulses("sim8", 1'b0, 1'b1, 1'b0);
    chk("sim8_count", 32'(g_count), 32'd7);
    chk("sim8_data", 32'(g_data_out), 32'h00A1);

    for (int i = 2; i <= 4; i++) begin
      step(1'b0, 1'b1, 16'h0000);
      chk("mid_data", 32'(g_data_out), 32'(16'h00A0 + i));
    end
    chk("mid_count", 32'(g_count), 32'd4);

    // Simultaneous at count 4: both accepted
    step(1'b1, 1'b1, 16'h00C0);
    chk_pulses("sim4", 1'b1, 1'b0, 1'b0);
    chk("sim4_count", 32'(g_count), 32'd4);
    chk("sim4_data", 32'(g_data_out), 32'h00A5);

    step(1'b0, 1'b1, 16'h0000);
    chk("order_a6", 32'(g_data_out), 32'h00A6);
    step(1'b0, 1'b1, 16'h0000);
    chk("order_a7", 32'(g_data_out), 32'h00A7);
    step(1'b0, 1'b1, 16'h0000);
    chk("order_a8", 32'(g_data_out), 32'h00A8);
    step(1'b0, 1'b1, 16'h0000);
    chk("order_c0", 32'(g_data_out), 32'h00C0);
    chk("order_empty", 32'(g_empty), 32'd1);

    // Pointer wrap with alternating write/read pairs
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, W'(i));
      chk("wrap_wcount", 32'(g_count), 32'd1);
      step(1'b0, 1'b1, 16'h0000);
      chk("wrap_data", 32'(g_data_out), 32'(i));
      chk("wrap_rcount", 32'(g_count), 32'd0);
    end

    // Asynchronous reset mid-cycle at count 5
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'(16'h0050 + i));
    chk("pre_rst_count", 32'(g_count), 32'd5);
    chk("pre_rst_ack", 32'(g_wr_ack), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(g_count), 32'd0);
    chk("arst_empty", 32'(g_empty), 32'd1);
    chk("arst_full", 32'(g_full), 32'd0);
    chk("arst_data", 32'(g_data_out), 32'd0);
    chk_pulses("arst", 1'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;

    step(1'b1, 1'b0, 16'hBEEF);
    chk("post_ack", 32'(g_wr_ack), 32'd1);
    chk("post_count", 32'(g_count), 32'd1);
    step(1'b0, 1'b1, 16'h0000);
    chk("post_data", 32'(g_data_out), 32'h0000BEEF);
    chk("post_empty", 32'(g_empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
